// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
// Sends one command byte from the host to a PS/2 device. It uses the
// request-to-send handshake, odd parity, a stop bit and a device acknowledge.
// The clock and data pins are shared with a receive path, and both are
// open-drain. The *_drive_low outputs pull a pin low. Otherwise the pin is released.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       Clock_50,
    input  logic       Resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_clock,
    input  logic       PS2_data,
    output logic       PS2_clock_drive_low,
    output logic       PS2_data_drive_low
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQUEST   = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_cnt;
    logic [8:0]       r_frame;      // {parity, data}; shifted LSB first
    logic             r_ack_ok;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_clk_low;
    logic             r_data_low;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_prev;
    logic             r_dat_s1;
    logic             r_dat_s2;

    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    // The pins are asynchronous to Clock_50. The previous synchronized clock
    // level is kept so that falling edges can be detected.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_s1   <= 1'b0;
            r_dat_s2   <= 1'b0;
        end else begin
            // NOTE: the logic reads only the second stage. The first stage may go metastable.
            r_clk_s1   <= PS2_clock;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= PS2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    // The shared counter saturates, so a stalled device can never wrap it back to zero.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Transmit FSM. It runs the handshake, shifts out the frame and registers every output.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_frame    <= '0;
            r_ack_ok   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout. Every branch reads the pre-edge values.
            r_done  <= 1'b0;
            r_error <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_clk_low  <= 1'b0;
                    r_data_low <= 1'b0;
                    r_busy     <= 1'b0;
                    if (tx_start && !r_busy) begin
                        r_frame   <= {~^tx_data, tx_data};
                        r_busy    <= 1'b1;
                        r_clk_low <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == INHIBIT_LAST) begin
                        r_data_low <= 1'b1;    // start bit
                        r_state    <= S_REQUEST;
                    end
                end

                S_REQUEST: begin
                    r_clk_low <= 1'b0;         // the device now drives the clock
                    r_bit_cnt <= '0;
                    r_cnt     <= '0;
                    r_state   <= S_SEND;
                end

                S_SEND: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == TIMEOUT_LAST) begin
                        r_clk_low  <= 1'b0;
                        r_data_low <= 1'b0;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_fall) begin
                        // Edges 1-9 send data then parity. A 1 is shifted in behind
                        // them, so edge 10 releases the line for the stop bit.
                        r_data_low <= ~r_frame[0];
                        r_frame    <= {1'b1, r_frame[8:1]};
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd9) begin
                            r_state <= S_ACK;
                        end
                    end
                end

                S_ACK: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == TIMEOUT_LAST) begin
                        r_clk_low  <= 1'b0;
                        r_data_low <= 1'b0;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_fall) begin
                        r_ack_ok <= ~r_dat_s2;
                        r_state  <= S_WAIT_IDLE;
                    end
                end

                S_WAIT_IDLE: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == TIMEOUT_LAST) begin
                        r_clk_low  <= 1'b0;
                        r_data_low <= 1'b0;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_clk_s2 && r_dat_s2) begin
                        r_done  <= r_ack_ok;
                        r_error <= ~r_ack_ok;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                // NOTE: the explicit default returns unused encodings to a safe, released idle state.
                default: begin
                    r_clk_low  <= 1'b0;
                    r_data_low <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_busy             = r_busy;
    assign tx_done             = r_done;
    assign tx_error            = r_error;
    assign PS2_clock_drive_low = r_clk_low;
    assign PS2_data_drive_low  = r_data_low;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed testbench for ps2_host_transmitter. A behavioural PS/2 device
// generates the clock, samples every bit the host sends and acknowledges.
module tb_ps2_host_transmitter;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 2000;

    logic       Clock_50 = 1'b0;
    logic       Resetn;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       PS2_clock;
    logic       PS2_data;
    logic       PS2_clock_drive_low;
    logic       PS2_data_drive_low;

    logic       dev_clk;
    logic       dev_data;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         both_cnt = 0;

    // Model the open-drain wired-AND bus: either side can pull a line low.
    assign PS2_clock = dev_clk  & ~PS2_clock_drive_low;
    assign PS2_data  = dev_data & ~PS2_data_drive_low;

    always #5 Clock_50 = ~Clock_50;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .Clock_50            (Clock_50),
        .Resetn              (Resetn),
        .tx_data             (tx_data),
        .tx_start            (tx_start),
        .tx_busy             (tx_busy),
        .tx_done             (tx_done),
        .tx_error            (tx_error),
        .PS2_clock           (PS2_clock),
        .PS2_data            (PS2_data),
        .PS2_clock_drive_low (PS2_clock_drive_low),
        .PS2_data_drive_low  (PS2_data_drive_low)
    );

    // Pulse counters, sampled on the inactive edge
    always @(negedge Clock_50) begin
        if (tx_done)             done_cnt++;
        if (tx_error)            err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse tx_start for one cycle. With timing=1, check the inhibit/request sequence.
    task automatic start_tx(input logic [7:0] d, input bit timing);
        @(negedge Clock_50);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge Clock_50);                  // cycle T+1
        tx_start = 1'b0;
        if (timing) begin
            check("busy_after_start", tx_busy, 1);
            check("clk_low_after_start", PS2_clock_drive_low, 1);
            check("data_rel_in_inhibit", PS2_data_drive_low, 0);
            repeat (INHIBIT - 1) @(negedge Clock_50);   // cycle T+INHIBIT
            check("data_rel_end_inhibit", PS2_data_drive_low, 0);
            check("clk_low_end_inhibit", PS2_clock_drive_low, 1);
            @(negedge Clock_50);              // cycle T+1+INHIBIT
            check("request_data_low", PS2_data_drive_low, 1);
            check("request_clk_low", PS2_clock_drive_low, 1);
            @(negedge Clock_50);              // cycle T+2+INHIBIT
            check("clk_released", PS2_clock_drive_low, 0);
            check("start_bit_held", PS2_data_drive_low, 1);
        end
    endtask

    // Device: n_edges clock periods of 40 cycles. Each bit is sampled just before
    // the rising edge. Edge 11 carries the ACK. With inject=1, a stray tx_start
    // (0x55) is pulsed during bit 3.
    task automatic dev_run(input int n_edges, input bit ack, input bit inject,
                           output logic [7:0] cap_byte, output logic cap_par,
                           output logic cap_stop);
        int w;
        logic s;
        w        = 0;
        cap_byte = '0;
        cap_par  = 1'b0;
        cap_stop = 1'b0;
        while (PS2_clock_drive_low && w < 100) begin
            @(negedge Clock_50);
            w++;
        end
        check("dev_sees_release", PS2_clock_drive_low, 0);
        for (int i = 1; i <= n_edges; i++) begin
            repeat (20) @(negedge Clock_50);
            dev_clk = 1'b0;
            if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
            for (int j = 0; j < 20; j++) begin
                @(negedge Clock_50);
                if (inject && i == 3 && j == 5) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                end else begin
                    tx_start = 1'b0;
                end
            end
            s = PS2_data;
            if (i <= 8)       cap_byte[i-1] = s;
            else if (i == 9)  cap_par  = s;
            else if (i == 10) cap_stop = s;
            dev_clk = 1'b1;
            if (i == 11) dev_data = 1'b1;
        end
    endtask

    task automatic wait_pulse(input string tag, output bit got_done, output bit got_err);
        int w;
        w = 0;
        while (!(tx_done || tx_error) && w < 300) begin
            @(negedge Clock_50);
            w++;
        end
        check({tag, "_pulse_seen"}, tx_done | tx_error, 1);
        got_done = tx_done;
        got_err  = tx_error;
    endtask

    // Run one complete transfer and check the captured frame and the result pulse.
    task automatic xfer(input string tag, input logic [7:0] d, input bit ack,
                        input bit inject, input logic exp_par);
        int d0, e0;
        logic [7:0] cb;
        logic cp, cs;
        bit gd, ge;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d, 1);
        dev_run(11, ack, inject, cb, cp, cs);
        wait_pulse(tag, gd, ge);
        check({tag, "_byte"}, cb, d);
        check({tag, "_parity"}, cp, exp_par);
        check({tag, "_stop"}, cs, 1);
        check({tag, "_done"}, gd, ack);
        check({tag, "_error"}, ge, !ack);
        @(negedge Clock_50);
        check({tag, "_busy_clear"}, tx_busy, 0);
        check({tag, "_clk_rel"}, PS2_clock_drive_low, 0);
        check({tag, "_data_rel"}, PS2_data_drive_low, 0);
        repeat (10) @(negedge Clock_50);
        check({tag, "_done_count"}, done_cnt - d0, ack ? 1 : 0);
        check({tag, "_error_count"}, err_cnt - e0, ack ? 0 : 1);
        check({tag, "_stays_idle"}, PS2_clock_drive_low | tx_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, d0, e0;
        logic [7:0] cb;
        logic cp, cs;

        Resetn   = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge Clock_50);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_clk_low", PS2_clock_drive_low, 0);
        check("rst_data_low", PS2_data_drive_low, 0);
        Resetn = 1'b1;
        repeat (5) @(negedge Clock_50);

        // 0xED: 6 ones -> parity 1; 0xF4: 5 ones -> 0; 0x00 -> 1
        xfer("ed", 8'hED, 1, 0, 1'b1);
        xfer("f4", 8'hF4, 1, 0, 1'b0);
        xfer("00", 8'h00, 1, 0, 1'b1);

        // No acknowledge: the device leaves data high on edge 11. 0xFF -> parity 1
        xfer("noack", 8'hFF, 0, 0, 1'b1);

        // Timeout: the device never clocks after the request
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'h12, 0);
        n = 0;
        while (PS2_clock_drive_low && n < INHIBIT + 10) begin
            @(negedge Clock_50);
            n++;
        end
        check("to_clk_released", PS2_clock_drive_low, 0);
        n = 0;
        while (!tx_error && n < TIMEOUT + 100) begin
            @(negedge Clock_50);
            n++;
        end
        check("to_latency", n, TIMEOUT);
        check("to_error", tx_error, 1);
        check("to_no_done", tx_done, 0);
        check("to_clk_rel", PS2_clock_drive_low, 0);
        check("to_data_rel", PS2_data_drive_low, 0);
        @(negedge Clock_50);
        check("to_busy_clear", tx_busy, 0);
        repeat (10) @(negedge Clock_50);
        check("to_error_count", err_cnt - e0, 1);
        check("to_done_count", done_cnt - d0, 0);

        // A stray tx_start during S_SEND is ignored. 0xA5 has 4 ones -> parity 1
        xfer("inject", 8'hA5, 1, 1, 1'b1);

        // Reset during bit 4 releases everything asynchronously
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h3C, 0);
        dev_run(4, 1, 0, cb, cp, cs);
        check("mid_busy_before_rst", tx_busy, 1);
        #2;
        Resetn = 1'b0;
        #1;
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_clk_low", PS2_clock_drive_low, 0);
        check("rst_mid_data_low", PS2_data_drive_low, 0);
        repeat (3) @(negedge Clock_50);
        Resetn = 1'b1;
        repeat (5) @(negedge Clock_50);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_no_error", err_cnt - e0, 0);

        // 0x96 has 4 ones -> parity 1
        xfer("post_rst", 8'h96, 1, 0, 1'b1);

        check("done_error_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
